crc8_serial_checker: RTL

- Receive-side counterpart of the team's serial LFSR CRC-8 generator.
- Consumes the serial data bits of a frame, then the 8 transmitted CRC bits (LSB first), and recomputes the CRC with the same LFSR, seed and taps.
- Reports per-frame pass/fail plus a one-cycle completion pulse.
- Sits in the serial receive path, after bit recovery and before frame acceptance logic.

---
 rtl/crc8_pkg.sv | 41 ++++
 rtl/crc8_lfsr_core.sv | 44 ++++
 rtl/crc8_serial_checker.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions for the serial generator and checker.
// Holds the polynomial constants, the checker state encoding, the LFSR
// operation codes and the single-bit data step used by both directions.
package crc8_pkg;

   localparam int               CRC8_WIDTH = 8;
   localparam logic [7:0]       CRC8_TAPS  = 8'b01000100;
   localparam logic [7:0]       CRC8_SEED  = 8'hD8;

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      CHECK,
      DONE_S
   } crc8_state_e;

   typedef enum logic [1:0] {
      LFSR_HOLD,
      LFSR_STEP,
      LFSR_SHIFT,
      LFSR_LOAD
   } lfsr_op_e;

   // One data bit through the LFSR: feedback enters the top stage and is
   // XORed into every stage whose tap bit is set.
   function automatic logic [CRC8_WIDTH-1:0] crc8_step(
      input logic [CRC8_WIDTH-1:0] r,
      input logic                  b,
      input logic [CRC8_WIDTH-1:0] taps
   );
      logic                  fb;
      logic [CRC8_WIDTH-1:0] n;
      fb = r[0] ^ b;
      n[CRC8_WIDTH-1] = fb;
      for (int i = 0; i < CRC8_WIDTH - 1; i++) begin
         n[i] = r[i+1] ^ (taps[i] & fb);
      end
      return n;
   endfunction

endpackage

// File: rtl/crc8_lfsr_core.sv
// CRC-8 LFSR register with step / shift / reload controls.
// Only the LSB leaves the core: the checker compares against it and a
// transmitter shifts it out, so both sides can share this block.
module crc8_lfsr_core
   import crc8_pkg::*;
#(
   parameter int               WIDTH = CRC8_WIDTH,
   parameter logic [WIDTH-1:0] TAPS  = CRC8_TAPS,
   parameter logic [WIDTH-1:0] SEED  = CRC8_SEED
) (
   input  logic     CLK,
   input  logic     RST,
   input  lfsr_op_e op,
   input  logic     from_seed,
   input  logic     din,
   output logic     lsb
);

   logic [WIDTH-1:0] crc_reg;
   logic [WIDTH-1:0] base;

   // Operations normally act on the live register; a frame start or an
   // abort operates on a fresh SEED instead within the same cycle.
   always_comb begin
      base = from_seed ? SEED : crc_reg;
   end

   // LFSR register: data step, plain right shift for CRC bits, or reload.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         crc_reg <= SEED;
      end else begin
         case (op)
            LFSR_STEP:  crc_reg <= crc8_step(base, din, TAPS);
            LFSR_SHIFT: crc_reg <= base >> 1;
            LFSR_LOAD:  crc_reg <= SEED;
            default:    crc_reg <= crc_reg;
         endcase
      end
   end

   assign lsb = crc_reg[0];

endmodule

// File: rtl/crc8_serial_checker.sv
// Serial CRC-8 receive checker: runs data bits through the LFSR, then
// compares the 8 received CRC bits (LSB first) against the register as
// it shifts out, and reports pass/fail with a one-cycle DONE pulse.
// Optional macro CRC_CHK_ERRCNT_EN adds a saturating bad-frame counter
// ERR_CNT with synchronous clear ERR_CLR.
module crc8_serial_checker
   import crc8_pkg::*;
#(
   parameter int               WIDTH = CRC8_WIDTH,
   parameter logic [WIDTH-1:0] TAPS  = CRC8_TAPS,
   parameter logic [WIDTH-1:0] SEED  = CRC8_SEED
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       DATA,
   input  logic       ACTIVE,
   input  logic       CRC_VALID,
`ifdef CRC_CHK_ERRCNT_EN
   input  logic       ERR_CLR,
   output logic [7:0] ERR_CNT,
`endif
   output logic       BUSY,
   output logic       DONE,
   output logic       CRC_OK,
   output logic       CRC_ERR
);

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH);

   crc8_state_e      state, state_nx;
   logic [CNT_W-1:0] bit_cnt, cnt_nx;
   logic             mismatch, mismatch_nx;
   lfsr_op_e         lfsr_op;
   logic             lfsr_from_seed;
   logic             crc_lsb;
   logic             ref_lsb;
   logic             bit_bad;
   logic             busy_nx, done_nx, ok_nx, err_nx;

   crc8_lfsr_core #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .SEED  (SEED)
   ) u_core (
      .CLK       (CLK),
      .RST       (RST),
      .op        (lfsr_op),
      .from_seed (lfsr_from_seed),
      .din       (DATA),
      .lsb       (crc_lsb)
   );

   // A zero-length frame compares its first CRC bit straight against SEED.
   always_comb begin
      ref_lsb = (state == crc8_pkg::IDLE) ? SEED[0] : crc_lsb;
      bit_bad = DATA ^ ref_lsb;
   end

   // Next-state and datapath control; ACTIVE always outranks CRC_VALID,
   // and inputs during the DONE_S cycle are ignored.
   always_comb begin
      state_nx       = state;
      cnt_nx         = bit_cnt;
      mismatch_nx    = mismatch;
      lfsr_op        = LFSR_HOLD;
      lfsr_from_seed = 1'b0;
      done_nx        = 1'b0;
      ok_nx          = CRC_OK;
      err_nx         = CRC_ERR;
      case (state)
         crc8_pkg::IDLE: begin
            if (ACTIVE) begin
               ok_nx          = 1'b0;
               err_nx         = 1'b0;
               lfsr_op        = LFSR_STEP;
               lfsr_from_seed = 1'b1;
               state_nx       = crc8_pkg::DATA;
            end else if (CRC_VALID) begin
               ok_nx          = 1'b0;
               err_nx         = 1'b0;
               lfsr_op        = LFSR_SHIFT;
               lfsr_from_seed = 1'b1;
               mismatch_nx    = bit_bad;
               cnt_nx         = CNT_W'(1);
               state_nx       = crc8_pkg::CHECK;
            end
         end
         crc8_pkg::DATA: begin
            if (ACTIVE) begin
               lfsr_op = LFSR_STEP;
            end else if (CRC_VALID) begin
               lfsr_op     = LFSR_SHIFT;
               mismatch_nx = mismatch | bit_bad;
               cnt_nx      = bit_cnt + CNT_W'(1);
               state_nx    = crc8_pkg::CHECK;
            end
         end
         crc8_pkg::CHECK: begin
            if (ACTIVE) begin
               lfsr_op        = LFSR_STEP;
               lfsr_from_seed = 1'b1;
               cnt_nx         = '0;
               mismatch_nx    = 1'b0;
               state_nx       = crc8_pkg::DATA;
            end else if (CRC_VALID) begin
               lfsr_op     = LFSR_SHIFT;
               mismatch_nx = mismatch | bit_bad;
               cnt_nx      = bit_cnt + CNT_W'(1);
               if (cnt_nx == LAST_CNT) begin
                  state_nx = crc8_pkg::DONE_S;
                  done_nx  = 1'b1;
                  ok_nx    = ~mismatch_nx;
                  err_nx   = mismatch_nx;
               end
            end
         end
         crc8_pkg::DONE_S: begin
            lfsr_op     = LFSR_LOAD;
            cnt_nx      = '0;
            mismatch_nx = 1'b0;
            state_nx    = crc8_pkg::IDLE;
         end
         default: begin
            state_nx = crc8_pkg::IDLE;
         end
      endcase
      busy_nx = (state_nx == crc8_pkg::DATA) || (state_nx == crc8_pkg::CHECK);
   end

   // Control state, CRC bit counter and sticky mismatch flag.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state    <= crc8_pkg::IDLE;
         bit_cnt  <= '0;
         mismatch <= 1'b0;
      end else begin
         state    <= state_nx;
         bit_cnt  <= cnt_nx;
         mismatch <= mismatch_nx;
      end
   end

   // Registered outputs so DONE and the verdict appear together in the
   // cycle after the last CRC bit is sampled.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         CRC_OK  <= 1'b0;
         CRC_ERR <= 1'b0;
      end else begin
         BUSY    <= busy_nx;
         DONE    <= done_nx;
         CRC_OK  <= ok_nx;
         CRC_ERR <= err_nx;
      end
   end

`ifdef CRC_CHK_ERRCNT_EN
   // Saturating bad-frame counter; a clear beats a same-cycle increment.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         ERR_CNT <= 8'h00;
      end else if (ERR_CLR) begin
         ERR_CNT <= 8'h00;
      end else if ((state == crc8_pkg::DONE_S) && mismatch && (ERR_CNT != 8'hFF)) begin
         ERR_CNT <= ERR_CNT + 8'h01;
      end
   end
`endif

endmodule
